banked_regfile_2r1w: RTL and testbench
======================================

# banked_regfile_2r1w

Parametrised banked register file with one write port and two independent read ports. Storage is split into SECTORS banks of DEPTH words of DATA_W bits; each port selects a bank and a word address. Reads are registered with write-first bypass, and a built-in clear engine zeroes all banks in DEPTH cycles. It is the weight/activation store feeding the autoencoder datapath and replaces the fixed 16×16×16 sector memory.

## Interface
- DATA_W, 16, word width in bits
- SECTORS, 16, number of banks (≥1, need not be a power of two)
- DEPTH, 16, words per bank (≥2)
- CLEAR_ON_RESET, 1, 1 = clear engine starts automatically after reset release
- SEL_W, $clog2(SECTORS), derived, not overridden
- ADDR_W, $clog2(DEPTH), derived, not overridden

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- write_enable  in  1  write request
- write_sector  in  SEL_W  target bank
- write_address  in  ADDR_W  target word
- data_write  in  DATA_W  write data
- read_en_1 / read_en_2  in  1  read request, port 1 / 2
- read_sector_1 / read_sector_2  in  SEL_W  bank select
- read_add_1 / read_add_2  in  ADDR_W  word address
- read_data_1 / read_data_2  out  DATA_W  registered read data
- read_valid_1 / read_valid_2  out  1  read_data_n valid this cycle
- clear_start  in  1  one-cycle pulse requesting full clear
- busy  out  1  clear engine running; writes and reads not accepted
- clear_done  out  1  one-cycle pulse at end of clear

## Operation
- FSM states: IDLE, CLEAR.
- Reset asserted: FSM → CLEAR if CLEAR_ON_RESET=1 else IDLE; clear counter=0; read_data_n=0, read_valid_n=0, clear_done=0; busy=CLEAR_ON_RESET. Array contents not reset directly.
- IDLE: write_enable=1 with write_sector<SECTORS and write_address<DEPTH writes data_write into that word at the edge. Out-of-range sector/address: write dropped, no side effects.
- IDLE → CLEAR on clear_start=1. CLEAR: each cycle writes 0 to word [counter] of all SECTORS banks in parallel; counter increments; after word DEPTH-1, FSM → IDLE, clear_done pulses one cycle, busy drops in that same cycle.
- clear_start while busy: ignored. write_enable while busy: dropped. read_en_n while busy: ignored, read_valid_n stays 0.
- Read port n (IDLE, read_en_n=1): next edge loads read_data_n with the addressed word and sets read_valid_n=1. Out-of-range sector or address returns 0 with read_valid_n=1.
- read_en_n=0: read_valid_n=0 next cycle; read_data_n holds its last value.
- Write-first bypass: if the write and a read in the same cycle hit the same bank and word, read_data_n gets data_write. Both ports may bypass simultaneously.
- Both ports may read the same location in the same cycle; no arbitration.

## Timing
- Write: data accepted at edge N; visible to reads issued in cycle N (bypass) and later.
- Read latency: 1 cycle; request in cycle N → read_data_n/read_valid_n valid in cycle N+1; throughput 1 read/port/cycle.
- Clear: clear_start sampled at edge N → busy=1 from N+1; DEPTH cycles in CLEAR; clear_done=1 and busy=0 in cycle N+DEPTH+1; first accepted access in that cycle.
- Auto-clear after reset: busy=1 from reset assertion; clear_done is DEPTH cycles after the first edge with reset low.
- Reset mid-clear: immediate abort and counter=0; restarts from word 0 if CLEAR_ON_RESET=1, else IDLE with partially cleared contents.
- Reset mid-read: read_valid_n and read_data_n go to 0 asynchronously; pending read lost.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=16 → busy=1 for 16 cycles after reset release, then clear_done pulse; all 256 words read back 0x0000 with read_valid=1 one cycle after each request.
- Write 0xA5A5 to sector 3 addr 7, then read port 1 sector 3 addr 7 and port 2 sector 4 addr 7 in the next cycle → read_data_1=0xA5A5, read_data_2=0x0000, both valids high.
- Same-cycle write 0x1234 to sector 15 addr 15 with both ports reading sector 15 addr 15 → both read_data=0x1234 next cycle.
- SECTORS=12: write 0xFFFF to sector 13 → dropped; read sector 13 → 0x0000 with valid; sector 0–11 contents unchanged.
- Fill memory, pulse clear_start, and assert write_enable plus read_en during busy → writes dropped, valids low, clear_done after 16 cycles; all words read back 0.
- Assert reset 5 cycles into a clear → outputs 0 immediately; clear restarts from word 0 and clear_done arrives 16 cycles after reset release.

Source files
------------

// File: rtl/banked_regfile_2r1w.sv
// Banked register file: one write port, two registered read ports with write-first bypass,
// and a clear engine that zeroes every bank one word index per cycle.
module banked_regfile_2r1w #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned SECTORS        = 16,
  parameter int unsigned DEPTH          = 16,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned SEL_W         = (SECTORS > 1) ? $clog2(SECTORS) : 1,
  localparam int unsigned ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [SEL_W-1:0]  write_sector,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_write,
  input  logic              read_en_1,
  input  logic [SEL_W-1:0]  read_sector_1,
  input  logic [ADDR_W-1:0] read_add_1,
  output logic [DATA_W-1:0] read_data_1,
  output logic              read_valid_1,
  input  logic              read_en_2,
  input  logic [SEL_W-1:0]  read_sector_2,
  input  logic [ADDR_W-1:0] read_add_2,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_valid_2,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done
);

  // One extra bit so SECTORS/DEPTH are representable even when they are powers of two.
  localparam logic [SEL_W:0]    NumSectors = (SEL_W + 1)'(SECTORS);
  localparam logic [ADDR_W:0]   NumWords   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clear_done_q, clear_done_d;

  logic [DATA_W-1:0]   mem [SECTORS][DEPTH];

  logic                wr_ok, rd_ok_1, rd_ok_2, rd_in_1, rd_in_2;
  logic [DATA_W-1:0]   rd_next_1, rd_next_2;

  assign busy       = (state_q == StClear);
  assign clear_done = clear_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) begin
          state_d      = StIdle;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state_q <= StClear;
      else                state_q <= StIdle;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign wr_ok   = write_enable && !busy && ({1'b0, write_sector} < NumSectors)
                   && ({1'b0, write_address} < NumWords);
  assign rd_in_1 = ({1'b0, read_sector_1} < NumSectors) && ({1'b0, read_add_1} < NumWords);
  assign rd_in_2 = ({1'b0, read_sector_2} < NumSectors) && ({1'b0, read_add_2} < NumWords);
  assign rd_ok_1 = read_en_1 && !busy;
  assign rd_ok_2 = read_en_2 && !busy;

  // Storage carries no reset; the clear engine owns initialisation.
  always_ff @(posedge clock) begin
    if (state_q == StClear) begin
      for (int unsigned s = 0; s < SECTORS; s++) mem[s][cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[write_sector][write_address] <= data_write;
    end
  end

  // Write-first: an accepted write to the same word overrides the array contents.
  always_comb begin
    rd_next_1 = '0;
    if (rd_in_1) rd_next_1 = mem[read_sector_1][read_add_1];
    if (wr_ok && write_sector == read_sector_1 && write_address == read_add_1)
      rd_next_1 = data_write;
    rd_next_2 = '0;
    if (rd_in_2) rd_next_2 = mem[read_sector_2][read_add_2];
    if (wr_ok && write_sector == read_sector_2 && write_address == read_add_2)
      rd_next_2 = data_write;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_1  <= '0;
      read_valid_1 <= 1'b0;
      read_data_2  <= '0;
      read_valid_2 <= 1'b0;
    end else begin
      read_valid_1 <= rd_ok_1;
      read_valid_2 <= rd_ok_2;
      if (rd_ok_1) read_data_1 <= rd_next_1;
      if (rd_ok_2) read_data_2 <= rd_next_2;
    end
  end

endmodule

// File: tb/tb_banked_regfile_2r1w.sv
// Directed bench for banked_regfile_2r1w: default 16x16x16 instance plus a SECTORS=12 copy
// driven by the same stimulus to exercise out-of-range sectors.
module tb_banked_regfile_2r1w;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [3:0]  write_sector, write_address;
  logic [15:0] data_write;
  logic        read_en_1, read_en_2;
  logic [3:0]  read_sector_1, read_add_1, read_sector_2, read_add_2;
  logic        clear_start;

  logic [15:0] rd1, rd2, rd1_b, rd2_b;
  logic        rv1, rv2, rv1_b, rv2_b, busy, busy_b, done, done_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  banked_regfile_2r1w dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_sector(write_sector),
    .write_address(write_address), .data_write(data_write),
    .read_en_1(read_en_1), .read_sector_1(read_sector_1), .read_add_1(read_add_1),
    .read_data_1(rd1), .read_valid_1(rv1),
    .read_en_2(read_en_2), .read_sector_2(read_sector_2), .read_add_2(read_add_2),
    .read_data_2(rd2), .read_valid_2(rv2),
    .clear_start(clear_start), .busy(busy), .clear_done(done)
  );

  banked_regfile_2r1w #(.SECTORS(12)) dut12 (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_sector(write_sector),
    .write_address(write_address), .data_write(data_write),
    .read_en_1(read_en_1), .read_sector_1(read_sector_1), .read_add_1(read_add_1),
    .read_data_1(rd1_b), .read_valid_1(rv1_b),
    .read_en_2(read_en_2), .read_sector_2(read_sector_2), .read_add_2(read_add_2),
    .read_data_2(rd2_b), .read_valid_2(rv2_b),
    .clear_start(clear_start), .busy(busy_b), .clear_done(done_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] pat(input logic [3:0] s, input logic [3:0] a);
    return {8'h50, s, a};
  endfunction

  // Call in the cycle reset drops; checks busy for 16 edges then the clear_done pulse.
  task automatic expect_clear(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        chk({tag, "_busy"}, {15'b0, busy}, 16'd1);
        chk({tag, "_done_early"}, {15'b0, done}, 16'd0);
      end else begin
        chk({tag, "_busy_end"}, {15'b0, busy}, 16'd0);
        chk({tag, "_done"}, {15'b0, done}, 16'd1);
      end
    end
    tick();
    chk({tag, "_done_pulse"}, {15'b0, done}, 16'd0);
  endtask

  task automatic read_all_zero(input string tag);
    logic [7:0] w1, w2;
    read_en_1 = 1'b1;
    read_en_2 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      w1 = 8'(i);
      w2 = 8'(i + 128);
      read_sector_1 = w1[7:4]; read_add_1 = w1[3:0];
      read_sector_2 = w2[7:4]; read_add_2 = w2[3:0];
      tick();
      chk({tag, "_d1"}, rd1, 16'h0000);
      chk({tag, "_v1"}, {15'b0, rv1}, 16'd1);
      chk({tag, "_d2"}, rd2, 16'h0000);
      chk({tag, "_v2"}, {15'b0, rv2}, 16'd1);
    end
    read_en_1 = 1'b0;
    read_en_2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    write_enable = 1'b0; write_sector = '0; write_address = '0; data_write = '0;
    read_en_1 = 1'b0; read_sector_1 = '0; read_add_1 = '0;
    read_en_2 = 1'b0; read_sector_2 = '0; read_add_2 = '0;
    clear_start = 1'b0;

    // Reset state
    tick();
    chk("rst_busy", {15'b0, busy}, 16'd1);
    chk("rst_done", {15'b0, done}, 16'd0);
    chk("rst_v1", {15'b0, rv1}, 16'd0);
    chk("rst_d1", rd1, 16'h0000);
    chk("rst_v2", {15'b0, rv2}, 16'd0);
    chk("rst_d2", rd2, 16'h0000);
    tick();
    reset = 1'b0;
    expect_clear("auto_clear");
    read_all_zero("post_reset");
    tick();
    chk("idle_v1", {15'b0, rv1}, 16'd0);
    chk("idle_v2", {15'b0, rv2}, 16'd0);

    // Write then read on both ports
    write_enable = 1'b1; write_sector = 4'd3; write_address = 4'd7; data_write = 16'hA5A5;
    tick();
    write_enable = 1'b0;
    read_en_1 = 1'b1; read_sector_1 = 4'd3; read_add_1 = 4'd7;
    read_en_2 = 1'b1; read_sector_2 = 4'd4; read_add_2 = 4'd7;
    tick();
    chk("wr_rd_d1", rd1, 16'hA5A5);
    chk("wr_rd_v1", {15'b0, rv1}, 16'd1);
    chk("wr_rd_d2", rd2, 16'h0000);
    chk("wr_rd_v2", {15'b0, rv2}, 16'd1);
    chk("s12_inrange_d1", rd1_b, 16'hA5A5);
    read_en_1 = 1'b0; read_en_2 = 1'b0;
    tick();
    chk("hold_v1", {15'b0, rv1}, 16'd0);
    chk("hold_d1", rd1, 16'hA5A5);

    // Same-cycle bypass on both ports
    write_enable = 1'b1; write_sector = 4'd15; write_address = 4'd15; data_write = 16'h1234;
    read_en_1 = 1'b1; read_sector_1 = 4'd15; read_add_1 = 4'd15;
    read_en_2 = 1'b1; read_sector_2 = 4'd15; read_add_2 = 4'd15;
    tick();
    write_enable = 1'b0; read_en_1 = 1'b0; read_en_2 = 1'b0;
    chk("bypass_d1", rd1, 16'h1234);
    chk("bypass_d2", rd2, 16'h1234);
    chk("bypass_v2", {15'b0, rv2}, 16'd1);
    chk("s12_bypass_oor_d1", rd1_b, 16'h0000);
    chk("s12_bypass_oor_v1", {15'b0, rv1_b}, 16'd1);

    // Sector 13: valid on the 16-bank copy, out of range on the 12-bank copy
    write_enable = 1'b1; write_sector = 4'd13; write_address = 4'd2; data_write = 16'hFFFF;
    tick();
    write_enable = 1'b0;
    read_en_1 = 1'b1; read_sector_1 = 4'd13; read_add_1 = 4'd2;
    read_en_2 = 1'b1; read_sector_2 = 4'd3; read_add_2 = 4'd7;
    tick();
    read_en_1 = 1'b0; read_en_2 = 1'b0;
    chk("s16_sec13_d1", rd1, 16'hFFFF);
    chk("s12_sec13_d1", rd1_b, 16'h0000);
    chk("s12_sec13_v1", {15'b0, rv1_b}, 16'd1);
    chk("s12_sec3_kept", rd2_b, 16'hA5A5);

    // Fill every word, spot-check, then clear with traffic during busy
    write_enable = 1'b1;
    for (int i = 0; i < 256; i++) begin
      write_sector = 4'(i / 16); write_address = 4'(i % 16);
      data_write = pat(4'(i / 16), 4'(i % 16));
      tick();
    end
    write_enable = 1'b0;
    read_en_1 = 1'b1; read_sector_1 = 4'd5; read_add_1 = 4'd9;
    read_en_2 = 1'b1; read_sector_2 = 4'd14; read_add_2 = 4'd0;
    tick();
    read_en_1 = 1'b0; read_en_2 = 1'b0;
    chk("fill_d1", rd1, 16'h5059);
    chk("fill_d2", rd2, 16'h50E0);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    write_enable = 1'b1; write_sector = 4'd0; write_address = 4'd0; data_write = 16'hBEEF;
    read_en_1 = 1'b1; read_sector_1 = 4'd0; read_add_1 = 4'd0;
    read_en_2 = 1'b1; read_sector_2 = 4'd1; read_add_2 = 4'd1;
    for (int k = 1; k <= 16; k++) begin
      chk("clr_busy", {15'b0, busy}, 16'd1);
      chk("clr_done_early", {15'b0, done}, 16'd0);
      chk("clr_v1", {15'b0, rv1}, 16'd0);
      chk("clr_v2", {15'b0, rv2}, 16'd0);
      clear_start = (k == 5);
      tick();
    end
    clear_start = 1'b0;
    chk("clr_end_busy", {15'b0, busy}, 16'd0);
    chk("clr_end_done", {15'b0, done}, 16'd1);
    chk("clr_end_v1", {15'b0, rv1}, 16'd0);
    chk("clr_end_d1", rd1, 16'h5059);
    write_enable = 1'b0; read_en_1 = 1'b0; read_en_2 = 1'b0;
    tick();
    chk("clr_done_pulse", {15'b0, done}, 16'd0);
    read_all_zero("post_clear");

    // Reset five cycles into a clear
    write_enable = 1'b1; write_sector = 4'd1; write_address = 4'd1; data_write = 16'h7777;
    tick();
    write_enable = 1'b0;
    read_en_1 = 1'b1; read_sector_1 = 4'd1; read_add_1 = 4'd1;
    tick();
    read_en_1 = 1'b0;
    chk("pre_abort_d1", rd1, 16'h7777);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_clear_busy", {15'b0, busy}, 16'd1);
    chk("mid_clear_hold", rd1, 16'h7777);
    reset = 1'b1;
    #1;
    chk("abort_d1", rd1, 16'h0000);
    chk("abort_v1", {15'b0, rv1}, 16'd0);
    chk("abort_busy", {15'b0, busy}, 16'd1);
    tick();
    reset = 1'b0;
    expect_clear("restart_clear");
    read_en_1 = 1'b1; read_sector_1 = 4'd1; read_add_1 = 4'd1;
    tick();
    read_en_1 = 1'b0;
    chk("restart_word", rd1, 16'h0000);
    chk("restart_v1", {15'b0, rv1}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
